// File: rtl/spi_pkg.sv
// Shared types for the duplex SPI master (spi_master_duplex, spi_sck_gen).
// The optional SPI_MASTER_LSB_FIRST_EN build adds an lsb_first input on the top level.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Edge counter must hold 0..2*DATA_WIDTH.
  function automatic int edge_cnt_w(input int data_width);
    return $clog2(2 * data_width + 1);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK timing for spi_master_duplex: half-period counter, SCK toggle, edge index and strobes.
// SPI_MASTER_LSB_FIRST_EN has no effect on this block.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic xfer,
  input  logic load,
  input  logic cpol_in,
  output logic sck,
  output logic phase_end,
  output logic lead_stb,
  output logic trail_stb,
  output logic first_edge,
  output logic last_edge
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int EW = edge_cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [EW-1:0] edge_k;
  logic          sck_q, sck_d;
  logic          edge_stb;

  // edge_k is the 1-based index of the SCK edge that fires this cycle.
  assign phase_end  = run && (cnt_q == CNT_MAX);
  assign edge_stb   = xfer && phase_end;
  assign edge_k     = edge_q + EW'(1);
  assign lead_stb   = edge_stb && edge_k[0];
  assign trail_stb  = edge_stb && !edge_k[0];
  assign first_edge = (edge_k == EW'(1));
  assign last_edge  = edge_stb && (edge_k == EDGE_LAST);
  assign sck        = sck_q;

  always_comb begin
    cnt_d = '0;
    if (run && !phase_end) cnt_d = cnt_q + CW'(1);
    edge_d = '0;
    if (xfer) edge_d = edge_stb ? edge_k : edge_q;
    sck_d = sck_q;
    if (load)          sck_d = cpol_in;
    else if (edge_stb) sck_d = !sck_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      edge_q <= '0;
      sck_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      sck_q  <= sck_d;
    end
  end

endmodule

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master with runtime CPOL/CPHA, multiple chip selects and CS setup/hold.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first input (per-transfer bit order).
module spi_master_duplex
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int NUM_CS     = 1,
  localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [CSW-1:0]        cs_sel,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  input  logic                  MISO,
  output logic                  ready,
  output logic                  MOSI,
  output logic                  SCK,
  output logic [NUM_CS-1:0]     CS_N,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done
);

  spi_state_t            state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [CSW-1:0]        cs_q, cs_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;
  logic                  lsb_q, lsb_d;
  logic                  lsb_in, accept, sample, shift;
  logic                  phase_end, lead_stb, trail_stb, first_edge, last_edge;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && start;
  assign ready    = (state_q == IDLE);
  assign MOSI     = mosi_q;
  assign CS_N     = cs_n_q;
  assign data_out = dout_q;
  assign done     = done_q;

  spi_sck_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_DIV    (CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (state_q != IDLE),
    .xfer       (state_q == XFER),
    .load       (accept),
    .cpol_in    (cpol),
    .sck        (SCK),
    .phase_end  (phase_end),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .first_edge (first_edge),
    .last_edge  (last_edge)
  );

  // The MSB (or LSB) is already on MOSI from accept, so cpha=1 skips driving on edge 1.
  assign sample = mode_q.cpha ? trail_stb : lead_stb;
  assign shift  = mode_q.cpha ? (lead_stb && !first_edge) : (trail_stb && !last_edge);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cs_d    = cs_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    mosi_d  = mosi_q;
    lsb_d   = lsb_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = LEAD;
          mode_d.cpol = cpol;
          mode_d.cpha = cpha;
          cs_d        = cs_sel;
          tx_d        = data_in;
          rx_d        = '0;
          lsb_d       = lsb_in;
          mosi_d      = lsb_in ? data_in[0] : data_in[DATA_WIDTH-1];
        end
      end
      LEAD: if (phase_end) state_d = XFER;
      XFER: begin
        if (sample) rx_d = lsb_q ? {MISO, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], MISO};
        if (shift) begin
          tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
          mosi_d = lsb_q ? tx_q[1] : tx_q[DATA_WIDTH-2];
        end
        if (last_edge) begin
          state_d = TRAIL;
          dout_d  = rx_d;
        end
      end
      TRAIL: begin
        if (phase_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // An out-of-range index simply matches no line.
    cs_n_d = '1;
    if (state_d != IDLE) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (cs_d == CSW'(i)) cs_n_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cs_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cs_n_q  <= '1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cs_q    <= cs_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      lsb_q   <= lsb_d;
    end
  end

endmodule
